// File: rtl/pll_wb_reconfig_ctrl.sv
// Wishbone reconfiguration master for a PLL register port: single reads and
// read-modify-write updates with readback verification and strobe timeout.
module pll_wb_reconfig_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic       PLLCLK,
  input  logic       RST_N,
  input  logic       CFG_REQ,
  input  logic       CFG_WE,
  input  logic [4:0] CFG_ADDR,
  input  logic [7:0] CFG_WDATA,
  input  logic [7:0] CFG_MASK,
  output logic       CFG_BUSY,
  output logic       CFG_DONE,
  output logic       CFG_ERR,
  output logic [7:0] CFG_RDATA,
  output logic       PLLSTB,
  output logic       PLLWE,
  output logic [4:0] PLLADDR,
  output logic [7:0] PLLDATI,
  input  logic [7:0] PLLDATO,
  input  logic       PLLACK
);

  typedef enum logic [2:0] {IDLE, RD, WR, VFY, FIN} state_t;

  // Every output is a field of this register, so all outputs come straight from flops.
  typedef struct packed {
    state_t     state;
    logic       we;
    logic [7:0] mask;
    logic [7:0] wdata;
    logic [7:0] cnt;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] rdata;
    logic       stb;
    logic       pwe;
    logic [4:0] paddr;
    logic [7:0] pdati;
  } regs_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  regs_t q, d;
  logic  launch;
  logic  timeout;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge PLLCLK or negedge RST_N) begin
    if (!RST_N) q <= '0;
    else        q <= d;
  end

  // NOTE: every field of d gets a value before any branch (d = q), so no
  // path through this block can leave a variable unassigned and infer a latch.
  always_comb begin
    d       = q;
    d.done  = 1'b0;
    launch  = 1'b0;
    timeout = q.stb && !PLLACK && (q.cnt == TO_LAST);

    unique case (q.state)
      IDLE: begin
        if (CFG_REQ) begin
          d.we    = CFG_WE;
          d.mask  = CFG_MASK;
          d.wdata = CFG_WDATA;
          d.paddr = CFG_ADDR;
          d.busy  = 1'b1;
          launch  = 1'b1;
          if (CFG_WE && CFG_MASK == 8'hFF) begin
            d.state = WR;
            d.pwe   = 1'b1;
            d.pdati = CFG_WDATA;
          end else begin
            d.state = RD;
            d.pwe   = 1'b0;
          end
        end
      end

      RD, WR, VFY: begin
        if (!q.stb) begin
          // Strobe was low for one cycle after the previous access; start this one.
          launch = 1'b1;
          d.pwe  = (q.state == WR);
        end else if (PLLACK) begin
          d.stb = 1'b0;
          d.pwe = 1'b0;
          if (q.state == RD && q.we && q.mask != 8'h00) begin
            d.state = WR;
            d.pdati = (PLLDATO & ~q.mask) | (q.wdata & q.mask);
          end else if (q.state == WR) begin
            d.state = VFY;
          end else begin
            d.state = FIN;
            d.done  = 1'b1;
            d.rdata = PLLDATO;
            d.err   = (q.state == VFY) && (((PLLDATO ^ q.wdata) & q.mask) != 8'h00);
          end
        end else if (timeout) begin
          d.stb   = 1'b0;
          d.pwe   = 1'b0;
          d.state = FIN;
          d.done  = 1'b1;
          d.err   = 1'b1;
          d.rdata = 8'h00;
        end
      end

      FIN: begin
        d.state = IDLE;
        d.busy  = 1'b0;
      end

      default: d = '0;
    endcase

    // Timeout counter restarts on every strobe rise and runs while the strobe is high.
    if (launch) begin
      d.stb = 1'b1;
      d.cnt = '0;
    end else if (q.stb) begin
      d.cnt = q.cnt + 8'd1;
    end
  end

  assign CFG_BUSY  = q.busy;
  assign CFG_DONE  = q.done;
  assign CFG_ERR   = q.err;
  assign CFG_RDATA = q.rdata;
  assign PLLSTB    = q.stb;
  assign PLLWE     = q.pwe;
  assign PLLADDR   = q.paddr;
  assign PLLDATI   = q.pdati;

endmodule

// File: tb/tb_pll_wb_reconfig_ctrl.sv
// Self-checking bench for pll_wb_reconfig_ctrl: directed vector table, hand
// sequences for reset/back-to-back corners, and random ops against a model.
module tb_pll_wb_reconfig_ctrl;

  localparam int TO = 4;

  logic       PLLCLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       CFG_REQ = 1'b0;
  logic       CFG_WE = 1'b0;
  logic [4:0] CFG_ADDR = '0;
  logic [7:0] CFG_WDATA = '0;
  logic [7:0] CFG_MASK = '0;
  logic       CFG_BUSY, CFG_DONE, CFG_ERR;
  logic [7:0] CFG_RDATA;
  logic       PLLSTB, PLLWE;
  logic [4:0] PLLADDR;
  logic [7:0] PLLDATI;
  logic [7:0] PLLDATO = '0;
  logic       PLLACK = 1'b0;

  int n_checks = 0;
  int n_errs = 0;

  // PLL register file as seen by the slave model, and the reference copy.
  logic [7:0] mem [32];
  logic [7:0] ref_mem [32];

  int         dly_tab [3];
  logic [7:0] xr = '0;
  logic       stray_ack = 1'b0;
  int         op_base = 0;

  int         n_rise = 0, hi_cnt = 0, cur_dly = 0, last_len = 0, proto_err = 0, done_cnt = 0;
  logic       prev_stb = 1'b0;
  logic       sv_we = 1'b0;
  logic [4:0] sv_addr = '0;
  logic [7:0] sv_dati = '0;

  pll_wb_reconfig_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .PLLCLK(PLLCLK), .RST_N(RST_N),
    .CFG_REQ(CFG_REQ), .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR),
    .CFG_WDATA(CFG_WDATA), .CFG_MASK(CFG_MASK),
    .CFG_BUSY(CFG_BUSY), .CFG_DONE(CFG_DONE), .CFG_ERR(CFG_ERR), .CFG_RDATA(CFG_RDATA),
    .PLLSTB(PLLSTB), .PLLWE(PLLWE), .PLLADDR(PLLADDR), .PLLDATI(PLLDATI),
    .PLLDATO(PLLDATO), .PLLACK(PLLACK)
  );

  always #5 PLLCLK = ~PLLCLK;

  // PLL slave: acks the n-th strobe of an op after dly_tab[n] high cycles and
  // flags any change of address/data/direction while a strobe is held.
  always @(negedge PLLCLK) begin
    if (!PLLSTB) begin
      PLLACK  = stray_ack;
      PLLDATO = 8'($urandom);
    end else begin
      if (!prev_stb) begin
        cur_dly = dly_tab[(n_rise - op_base > 2) ? 2 : (n_rise - op_base)];
        n_rise++;
        hi_cnt  = 0;
        sv_we   = PLLWE;
        sv_addr = PLLADDR;
        sv_dati = PLLDATI;
      end else if ({PLLWE, PLLADDR, PLLDATI} != {sv_we, sv_addr, sv_dati}) begin
        proto_err++;
      end
      if (hi_cnt == cur_dly) begin
        PLLACK = 1'b1;
        if (PLLWE) mem[PLLADDR] = PLLDATI;
        else       PLLDATO = mem[PLLADDR] ^ xr;
      end else begin
        PLLACK  = 1'b0;
        PLLDATO = 8'($urandom);
      end
      hi_cnt++;
      last_len = hi_cnt;
    end
    prev_stb = PLLSTB;
    if (CFG_DONE) done_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called just after a negedge; the following posedge is the accept edge.
  task automatic issue(input logic we, input logic [4:0] a, input logic [7:0] wd, input logic [7:0] mk);
    op_base   = n_rise;
    CFG_WE    = we;
    CFG_ADDR  = a;
    CFG_WDATA = wd;
    CFG_MASK  = mk;
    CFG_REQ   = 1'b1;
    @(posedge PLLCLK);
    #1 CFG_REQ = 1'b0;
  endtask

  // lat = number of cycles after the accept edge until the CFG_DONE cycle.
  task automatic wait_done(input string tag, input int n0, input logic exp_we,
                           output int lat, output logic err, output logic [7:0] rd);
    bit seen;
    seen = 0; lat = 0; err = 1'b0; rd = '0;
    for (int n = n0; n <= 64 && !seen; n++) begin
      @(negedge PLLCLK); #1;
      if (n == 1) begin
        check({tag, "_stb_first_cycle"}, 32'(PLLSTB), 32'd1);
        check({tag, "_we_first_cycle"}, 32'(PLLWE), 32'(exp_we));
      end
      if (CFG_DONE) begin
        seen = 1; lat = n; err = CFG_ERR; rd = CFG_RDATA;
        check({tag, "_busy_in_fin"}, 32'(CFG_BUSY), 32'd1);
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    @(negedge PLLCLK); #1;
    check({tag, "_done_one_cycle_then_idle"}, 32'({CFG_DONE, CFG_BUSY}), 32'd0);
  endtask

  // Reference: plan the access sequence from the operation type, then walk it.
  task automatic model_op(input logic we, input logic [4:0] a, input logic [7:0] wd, input logic [7:0] mk,
                          output logic e, output logic [7:0] rd, output int lat, output int nstb);
    int         plan[$];
    logic [7:0] v;
    if (!we || mk == 8'h00)  plan = '{0};
    else if (mk == 8'hFF)    plan = '{1, 0};
    else                     plan = '{0, 1, 0};
    lat = 0; nstb = 0; e = 1'b0; rd = '0; v = '0;
    foreach (plan[i]) begin
      nstb++;
      if (dly_tab[i] >= TO) begin
        lat += TO; e = 1'b1; rd = 8'h00;
        break;
      end
      lat += dly_tab[i] + 1;
      if (plan[i] == 1) ref_mem[a] = (wd & mk) | (v & ~mk);
      else              v = ref_mem[a] ^ xr;
      if (i == plan.size() - 1) begin
        rd = v;
        e  = we && ((v & mk) != (wd & mk));
      end
    end
    lat += nstb;
  endtask

  typedef struct {
    logic       we;
    logic [4:0] addr;
    logic [7:0] wdata, mask, init, xr;
    int         d0, d1, d2;
    logic       e_err;
    logic [7:0] e_rdata;
    int         e_nstb, e_len, e_lat;
    logic [7:0] e_final;
  } vec_t;

  initial begin
    vec_t       vecs [9];
    logic [2:0] bb_exp [4];
    int         lat, m_lat, m_nstb, dc, hits;
    logic       err, m_err, r_we;
    logic [7:0] rd, m_rd, r_wd, r_mk;
    logic [4:0] r_a;
    string      tag;

    //            we   addr   wdata  mask   init   xr     d0 d1 d2  err   rdata  nstb len lat final
    vecs[0] = '{1'b0, 5'h03, 8'h00, 8'h00, 8'h5A, 8'h00, 2, 0, 0, 1'b0, 8'h5A, 1, 3, 4, 8'h5A};
    vecs[1] = '{1'b1, 5'h08, 8'hF0, 8'h0F, 8'hA5, 8'h00, 0, 0, 0, 1'b0, 8'hA0, 3, 1, 6, 8'hA0};
    vecs[2] = '{1'b1, 5'h10, 8'h3C, 8'hFF, 8'h00, 8'h01, 0, 0, 0, 1'b1, 8'h3D, 2, 1, 4, 8'h3C};
    vecs[3] = '{1'b0, 5'h1F, 8'h00, 8'h00, 8'h77, 8'h00, 9, 0, 0, 1'b1, 8'h00, 1, 4, 5, 8'h77};
    vecs[4] = '{1'b1, 5'h05, 8'hFF, 8'h00, 8'h33, 8'h00, 0, 0, 0, 1'b0, 8'h33, 1, 1, 2, 8'h33};
    vecs[5] = '{1'b1, 5'h06, 8'h0F, 8'hF0, 8'h12, 8'h00, 1, 9, 0, 1'b1, 8'h00, 2, 4, 8, 8'h12};
    vecs[6] = '{1'b1, 5'h07, 8'h80, 8'h80, 8'h01, 8'h80, 0, 0, 0, 1'b1, 8'h01, 3, 1, 6, 8'h81};
    vecs[7] = '{1'b0, 5'h0A, 8'h00, 8'h00, 8'hC3, 8'h00, 3, 0, 0, 1'b0, 8'hC3, 1, 4, 5, 8'hC3};
    vecs[8] = '{1'b1, 5'h0B, 8'h55, 8'hFF, 8'h00, 8'h00, 0, 4, 0, 1'b1, 8'h00, 2, 4, 7, 8'h55};
    bb_exp = '{3'b110, 3'b011, 3'b000, 3'b110};
    dly_tab = '{0, 0, 0};
    for (int i = 0; i < 32; i++) mem[i] = '0;

    // Reset state.
    repeat (3) @(negedge PLLCLK);
    #1;
    check("reset_outputs",
          32'({CFG_BUSY, CFG_DONE, CFG_ERR, CFG_RDATA, PLLSTB, PLLWE, PLLADDR, PLLDATI}), 32'd0);
    RST_N = 1'b1;

    // Directed vectors.
    foreach (vecs[i]) begin
      tag = $sformatf("vec%0d", i);
      mem[vecs[i].addr] = vecs[i].init;
      xr = vecs[i].xr;
      dly_tab = '{vecs[i].d0, vecs[i].d1, vecs[i].d2};
      issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].mask);
      wait_done(tag, 1, vecs[i].we && vecs[i].mask == 8'hFF, lat, err, rd);
      check({tag, "_err"}, 32'(err), 32'(vecs[i].e_err));
      check({tag, "_rdata"}, 32'(rd), 32'(vecs[i].e_rdata));
      check({tag, "_latency"}, 32'(lat), 32'(vecs[i].e_lat));
      check({tag, "_strobes"}, 32'(n_rise - op_base), 32'(vecs[i].e_nstb));
      check({tag, "_last_strobe_len"}, 32'(last_len), 32'(vecs[i].e_len));
      check({tag, "_reg_final"}, 32'(mem[vecs[i].addr]), 32'(vecs[i].e_final));
    end
    xr = '0;

    // Request pulsed while busy is ignored.
    mem[5'h04] = 8'h44;
    mem[5'h1F] = 8'h77;
    dly_tab = '{2, 0, 0};
    issue(1'b0, 5'h04, 8'h00, 8'h00);
    @(negedge PLLCLK); #1;
    CFG_WE = 1'b1; CFG_ADDR = 5'h1F; CFG_WDATA = 8'hEE; CFG_MASK = 8'hFF; CFG_REQ = 1'b1;
    @(negedge PLLCLK); #1;
    CFG_REQ = 1'b0;
    wait_done("busy_ignore", 3, 1'b0, lat, err, rd);
    check("busy_ignore_rdata", 32'(rd), 32'h44);
    check("busy_ignore_latency", 32'(lat), 32'd4);
    hits = 0;
    repeat (3) begin
      @(negedge PLLCLK); #1;
      hits += int'(PLLSTB) + int'(CFG_BUSY);
    end
    check("busy_ignore_no_queue", 32'(hits + n_rise - op_base), 32'd1);
    check("busy_ignore_reg_untouched", 32'(mem[5'h1F]), 32'h77);

    // Stray ACK while idle, then back-to-back with CFG_REQ held high.
    stray_ack = 1'b1;
    hits = 0;
    repeat (3) begin
      @(negedge PLLCLK); #1;
      hits += int'(PLLSTB) + int'(CFG_BUSY) + int'(CFG_DONE);
    end
    check("stray_ack_idle", 32'(hits), 32'd0);
    mem[5'h03] = 8'h5A;
    dly_tab = '{0, 0, 0};
    op_base = n_rise;
    CFG_WE = 1'b0; CFG_ADDR = 5'h03; CFG_MASK = 8'h00; CFG_REQ = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      @(negedge PLLCLK); #1;
      check($sformatf("b2b_cycle%0d_stb_busy_done", n), 32'({PLLSTB, CFG_BUSY, CFG_DONE}), 32'(bb_exp[n-1]));
    end
    CFG_REQ = 1'b0;
    wait_done("b2b_second", 2, 1'b0, lat, err, rd);
    check("b2b_second_rdata", 32'(rd), 32'h5A);
    check("b2b_second_err", 32'(err), 32'd0);
    check("b2b_strobes", 32'(n_rise - op_base), 32'd2);
    stray_ack = 1'b0;

    // Reset in the middle of a write strobe.
    mem[5'h0C] = 8'h00;
    dly_tab = '{9, 0, 0};
    issue(1'b1, 5'h0C, 8'h77, 8'hFF);
    @(negedge PLLCLK); #1;
    @(negedge PLLCLK); #1;
    check("rst_mid_write_strobe_active", 32'({PLLSTB, PLLWE}), 32'd3);
    #2 RST_N = 1'b0;
    #1;
    check("rst_mid_write_outputs_cleared",
          32'({CFG_BUSY, CFG_DONE, CFG_ERR, CFG_RDATA, PLLSTB, PLLWE, PLLADDR, PLLDATI}), 32'd0);
    dc = done_cnt;
    repeat (2) @(negedge PLLCLK);
    dly_tab = '{0, 0, 0};
    op_base = n_rise;
    CFG_WE = 1'b0; CFG_ADDR = 5'h0C; CFG_MASK = 8'h00; CFG_REQ = 1'b1;
    #1 RST_N = 1'b1;
    @(posedge PLLCLK);
    #1 CFG_REQ = 1'b0;
    wait_done("rst_then_read", 1, 1'b0, lat, err, rd);
    check("rst_then_read_latency", 32'(lat), 32'd2);
    check("rst_then_read_rdata", 32'(rd), 32'h00);
    check("rst_then_read_err", 32'(err), 32'd0);
    check("rst_no_done_for_aborted", 32'(done_cnt - dc), 32'd1);

    // Random operations against the reference model.
    for (int i = 0; i < 32; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    for (int k = 0; k < 150; k++) begin
      r_we = 1'($urandom_range(0, 1));
      r_a  = 5'($urandom_range(0, 31));
      r_wd = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       r_mk = 8'hFF;
        1:       r_mk = 8'h00;
        default: r_mk = 8'($urandom);
      endcase
      for (int j = 0; j < 3; j++)
        dly_tab[j] = ($urandom_range(0, 7) == 0) ? TO + int'($urandom_range(0, 3)) : int'($urandom_range(0, TO - 1));
      model_op(r_we, r_a, r_wd, r_mk, m_err, m_rd, m_lat, m_nstb);
      tag = $sformatf("rnd%0d", k);
      issue(r_we, r_a, r_wd, r_mk);
      wait_done(tag, 1, r_we && r_mk == 8'hFF, lat, err, rd);
      check({tag, "_err"}, 32'(err), 32'(m_err));
      check({tag, "_rdata"}, 32'(rd), 32'(m_rd));
      check({tag, "_latency"}, 32'(lat), 32'(m_lat));
      check({tag, "_strobes"}, 32'(n_rise - op_base), 32'(m_nstb));
      check({tag, "_reg"}, 32'(mem[r_a]), 32'(ref_mem[r_a]));
    end

    check("strobe_fields_stable_and_gapped", 32'(proto_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
